// File: rtl/bfusion1d_mac_seq.sv
// Job sequencer for one 1D BitFusion MAC: streams a job's operands into the MAC and returns its dot product.
// Latency: result valid 4 cycles after the last operand is accepted; op_ready only in RUN, cfg_ready only in IDLE.
// Backpressure: res_z is held until res_ready; BFSEQ_SAT_EN adds clamping and the res_sat flag.
module bfusion1d_mac_seq #(
  parameter int HEADROOM = 4,
  parameter int LEN_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_mode,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [15:0]            op_a,
  input  logic [7:0]             op_w,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [16+HEADROOM-1:0] res_z,
`ifdef BFSEQ_SAT_EN
  output logic                   res_sat,
`endif
  output logic                   mac_rst,
  output logic                   mac_accu_rst,
  output logic [15:0]            mac_a,
  output logic [7:0]             mac_w,
  output logic                   mac_mode,
  input  logic [16+HEADROOM-1:0] mac_z
);

  localparam int ZW = 16 + HEADROOM;
  localparam int MW = 13 + HEADROOM;

  typedef enum logic [2:0] {S_HOLD, S_IDLE, S_RUN, S_DRAIN, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_hold;
  logic [1:0]            r_drn;
  logic [LEN_W-1:0]      r_cnt, r_len;
  logic                  r_mode;
  logic [ZW-1:0]         r_res;
  logic                  w_last;
  logic signed [ZW-1:0]  w_full, w_res;

  assign w_last   = (r_cnt == r_len);
  assign mac_rst  = rst;
  assign mac_mode = r_mode;
  assign res_z    = r_res;

  // Mode 1 leaves the MAC's upper accumulator bits stale, so only the low part is trusted.
  assign w_full = r_mode ? {{(ZW-MW){mac_z[MW-1]}}, mac_z[MW-1:0]} : mac_z;

`ifdef BFSEQ_SAT_EN
  logic signed [ZW-1:0] w_lo, w_hi;
  logic                 w_sat, r_sat;
  assign res_sat = r_sat;
  always_comb begin
    w_lo  = r_mode ? ZW'(-4096) : ZW'(-32768);
    w_hi  = r_mode ? ZW'(4095)  : ZW'(32767);
    w_res = w_full;
    w_sat = 1'b0;
    if (w_full < w_lo) begin
      w_res = w_lo;
      w_sat = 1'b1;
    end else if (w_full > w_hi) begin
      w_res = w_hi;
      w_sat = 1'b1;
    end
  end
`else
  assign w_res = w_full;
`endif

  always_comb begin
    w_next       = r_state;
    cfg_ready    = 1'b0;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    mac_accu_rst = 1'b0;
    mac_a        = '0;
    mac_w        = '0;
    case (r_state)
      S_HOLD:  if (r_hold) w_next = S_IDLE;
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) w_next = S_RUN;
      end
      S_RUN: begin
        op_ready = 1'b1;
        if (op_valid) begin
          mac_a        = op_a;
          mac_w        = op_w;
          mac_accu_rst = (r_cnt == '0);
          if (w_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: if (r_drn == 2'd2) w_next = S_RESP;
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_HOLD;
    endcase
    // Never hand out a handshake or drive the MAC during a reset cycle.
    if (rst) begin
      cfg_ready    = 1'b0;
      op_ready     = 1'b0;
      mac_accu_rst = 1'b0;
      mac_a        = '0;
      mac_w        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HOLD;
      r_hold  <= 1'b0;
      r_drn   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mode  <= 1'b0;
      r_res   <= '0;
`ifdef BFSEQ_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_HOLD: r_hold <= 1'b1;
        S_IDLE: if (cfg_valid) begin
          r_mode <= cfg_mode;
          r_len  <= cfg_len;
          r_cnt  <= '0;
        end
        S_RUN: if (op_valid) begin
          r_cnt <= r_cnt + 1'b1;
          r_drn <= '0;
        end
        S_DRAIN: begin
          r_drn <= r_drn + 1'b1;
          if (r_drn == 2'd2) begin
            r_res <= w_res;
`ifdef BFSEQ_SAT_EN
            r_sat <= w_sat;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfusion1d_mac_seq.sv
// Bench for bfusion1d_mac_seq: table-driven jobs against a timing model of the BitFusion MAC,
// plus hand sequences for result stall and mid-job reset.
module tb_bfusion1d_mac_seq;

  localparam int H  = 4;
  localparam int ZW = 16 + H;
  localparam int MW = 13 + H;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_mode;
  logic [7:0]    cfg_len;
  logic          op_valid, op_ready;
  logic [15:0]   op_a;
  logic [7:0]    op_w;
  logic          res_valid, res_ready;
  logic [ZW-1:0] res_z;
  logic          mac_rst, mac_accu_rst, mac_mode;
  logic [15:0]   mac_a;
  logic [7:0]    mac_w;
  logic [ZW-1:0] mac_z;
`ifdef BFSEQ_SAT_EN
  logic          res_sat;
`endif

  bfusion1d_mac_seq #(.HEADROOM(H), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_w(op_w),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
`ifdef BFSEQ_SAT_EN
    .res_sat(res_sat),
`endif
    .mac_rst(mac_rst), .mac_accu_rst(mac_accu_rst), .mac_a(mac_a), .mac_w(mac_w),
    .mac_mode(mac_mode), .mac_z(mac_z)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC timing model: accu_rst at t clears at t+2, the product of t lands at t+3.
  function automatic int prod(input logic [15:0] a, input logic [7:0] w, input logic m);
    logic signed [7:0] w8;
    logic signed [3:0] wh, wl;
    w8 = w;
    wh = w[7:4];
    wl = w[3:0];
    if (m) return int'(a[15:8]) * int'(wh) + int'(a[7:0]) * int'(wl);
    return int'(a[7:0]) * int'(w8);
  endfunction

  int   p1, p2;
  logic m1, m2, ar1;
  always @(posedge clk) begin
    if (mac_rst) begin
      p1 <= 0; p2 <= 0; m1 <= 1'b0; m2 <= 1'b0; ar1 <= 1'b0; mac_z <= '0;
    end else begin
      p1  <= prod(mac_a, mac_w, mac_mode);
      m1  <= mac_mode;
      ar1 <= mac_accu_rst;
      p2  <= p1;
      m2  <= m1;
      if (ar1)     mac_z <= '0;
      else if (m2) mac_z <= {mac_z[ZW-1:MW], mac_z[MW-1:0] + MW'(p2)};
      else         mac_z <= mac_z + ZW'(p2);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic              mode;
    logic [7:0]        len;
    int                gap;
    logic [16:0][15:0] a;
    logic [16:0][7:0]  w;
    int                raw;
  } vec_t;

  vec_t tab[5];

  function automatic void expect_res(input int raw, input logic mode, output int z, output int sat);
`ifdef BFSEQ_SAT_EN
    int lo, hi;
    lo = mode ? -4096 : -32768;
    hi = mode ? 4095 : 32767;
    z = raw; sat = 0;
    if (raw < lo) begin z = lo; sat = 1; end
    else if (raw > hi) begin z = hi; sat = 1; end
`else
    z = raw; sat = 0;
`endif
  endfunction

  task automatic run_job(input vec_t v, input int stall);
    int guard, t_last, ez, es;
    guard = 0;
    while (!cfg_ready && guard < 20) begin step(); guard++; end
    check("cfg_ready_idle", int'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_mode = v.mode; cfg_len = v.len;
    step();
    cfg_valid = 1'b0;
    t_last = 0;
    for (int k = 0; k <= int'(v.len); k++) begin
      if (k > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          op_valid = 1'b0; op_a = 16'hBEEF; op_w = 8'h55;
          #1;
          check("bubble_mac_a", int'(mac_a), 0);
          check("bubble_accu_rst", int'(mac_accu_rst), 0);
          step();
        end
      end
      op_valid = 1'b1; op_a = v.a[k]; op_w = v.w[k];
      #1;
      check("op_ready", int'(op_ready), 1);
      check("accu_rst", int'(mac_accu_rst), (k == 0) ? 1 : 0);
      check("mac_a", int'(mac_a), int'(v.a[k]));
      check("mac_mode", int'(mac_mode), int'(v.mode));
      t_last = cyc;
      step();
    end
    op_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < 20) begin step(); guard++; end
    expect_res(v.raw, v.mode, ez, es);
    check("res_latency", cyc - t_last, 4);
    check("res_z", int'($signed(res_z)), ez);
`ifdef BFSEQ_SAT_EN
    check("res_sat", int'(res_sat), es);
`endif
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", int'(res_valid), 1);
      check("stall_res_z", int'($signed(res_z)), ez);
      check("stall_cfg_ready", int'(cfg_ready), 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("res_valid_drop", int'(res_valid), 0);
  endtask

  // Expects rst just released at a negedge; HOLD must last two edges.
  task automatic check_hold();
    for (int c = 0; c < 2; c++) begin
      check("hold_cfg_ready", int'(cfg_ready), 0);
      check("hold_op_ready", int'(op_ready), 0);
      check("hold_res_valid", int'(res_valid), 0);
      check("hold_res_z", int'(res_z), 0);
      check("hold_mac_a", int'(mac_a), 0);
      check("hold_mac_w", int'(mac_w), 0);
      check("hold_accu_rst", int'(mac_accu_rst), 0);
      check("hold_mac_mode", int'(mac_mode), 0);
      step();
    end
    check("hold_exit", int'(cfg_ready), 1);
    op_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      tab[i].a = '0; tab[i].w = '0; tab[i].gap = 0;
    end
    tab[0].mode = 1'b0; tab[0].len = 8'd2; tab[0].raw = 60;
    tab[0].a[0] = 16'd10; tab[0].w[0] = 8'd1;
    tab[0].a[1] = 16'd20; tab[0].w[1] = 8'hFE;
    tab[0].a[2] = 16'd30; tab[0].w[2] = 8'd3;
    tab[1].mode = 1'b1; tab[1].len = 8'd1; tab[1].raw = -246;
    tab[1].a[0] = 16'h0705; tab[1].w[0] = 8'h2F;
    tab[1].a[1] = 16'hFFFF; tab[1].w[1] = 8'h78;
    tab[2].mode = 1'b0; tab[2].len = 8'd3; tab[2].gap = 2; tab[2].raw = -400;
    for (int k = 0; k < 4; k++) begin tab[2].a[k] = 16'd100; tab[2].w[k] = 8'hFF; end
    tab[3].mode = 1'b0; tab[3].len = 8'd0; tab[3].raw = 1;
    tab[3].a[0] = 16'd1; tab[3].w[0] = 8'd1;
    tab[4].mode = 1'b0; tab[4].len = 8'd1; tab[4].raw = -65280;
    tab[4].a[0] = 16'h00FF; tab[4].w[0] = 8'h80;
    tab[4].a[1] = 16'h00FF; tab[4].w[1] = 8'h80;

    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
    op_valid = 1'b0; op_a = '0; op_w = '0; res_ready = 1'b0;
    repeat (3) step();
    check("rst_mac_rst", int'(mac_rst), 1);
    rst = 1'b0;
    op_valid = 1'b1; op_a = 16'h1234; op_w = 8'h34;
    #1;
    check_hold();

    for (int i = 0; i < 5; i++) run_job(tab[i], 0);

    run_job(tab[0], 5);
    run_job(tab[1], 0);

    // Reset in RUN after 2 of 5 elements: job discarded, no result.
    cfg_valid = 1'b1; cfg_mode = 1'b0; cfg_len = 8'd4;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1; op_a = 16'd50; op_w = 8'd2;
      step();
    end
    rst = 1'b1; op_a = 16'h1234; op_w = 8'h34;
    #1;
    check("midrst_mac_rst", int'(mac_rst), 1);
    step();
    rst = 1'b0;
    #1;
    check_hold();
    run_job(tab[3], 0);

`ifdef BFSEQ_SAT_EN
    begin
      vec_t sv;
      sv.mode = 1'b1; sv.len = 8'd16; sv.gap = 0; sv.raw = -34680;
      sv.a = '0; sv.w = '0;
      for (int k = 0; k < 17; k++) begin sv.a[k] = 16'hFF00; sv.w[k] = 8'h80; end
      run_job(sv, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
